// File: rtl/tetris_if.sv
// Command / status bundle for tetris_core.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_piece stable while cmd_valid is high, and cmd_ready
// never depends on cmd_valid.
// fsm_state encoding: 0 IDLE, 1 ACTIVE, 2 DROP, 3 CLEAR, 4 OVER.
`timescale 1ns/1ps
interface tetris_if #(
  parameter int MEM_WIDTH   = 10,
  parameter int MEM_HEIGHT  = 20,
  parameter int SCORE_WIDTH = 16
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [2:0]                    cmd_op;
  logic [15:0]                   cmd_piece;
  logic [$clog2(MEM_HEIGHT)-1:0] row_sel;
  logic [MEM_WIDTH-1:0]          row_data;
  logic [$clog2(MEM_WIDTH)-1:0]  piece_x;
  logic [$clog2(MEM_HEIGHT)-1:0] piece_y;
  logic [SCORE_WIDTH-1:0]        lines_cleared;
  logic                          game_over;
  logic [2:0]                    fsm_state;

  modport master (
    output cmd_valid, cmd_op, cmd_piece, row_sel,
    input  cmd_ready, row_data, piece_x, piece_y, lines_cleared, game_over, fsm_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_piece, row_sel,
    output cmd_ready, row_data, piece_x, piece_y, lines_cleared, game_over, fsm_state
  );
endinterface

// File: rtl/tetris_core.sv
// Tetris game engine: locked board, active piece, collision, gravity, hard drop
// and a one-row-per-cycle line-clear sequencer.
// Optional feature macro: TETRIS_ROTATE_EN (clockwise rotation on op 6).
`timescale 1ns/1ps
module tetris_core #(
  parameter int MEM_WIDTH      = 10,
  parameter int MEM_HEIGHT     = 20,
  parameter int GRAVITY_PERIOD = 1000,
  parameter int SCORE_WIDTH    = 16,
  parameter int SPAWN_X        = 3
) (
  input logic     clk,
  input logic     rst,
  tetris_if.slave bus
);
  localparam int XW = $clog2(MEM_WIDTH);
  localparam int YW = $clog2(MEM_HEIGHT);
  localparam int GW = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;
  localparam logic [GW-1:0] GRAV_LAST = GW'((GRAVITY_PERIOD > 0) ? GRAVITY_PERIOD - 1 : 0);

  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_DOWN  = 3'd3;
  localparam logic [2:0] OP_DROP  = 3'd4;
  localparam logic [2:0] OP_SPAWN = 3'd5;
`ifdef TETRIS_ROTATE_EN
  localparam logic [2:0] OP_ROT   = 3'd6;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ACTIVE = 3'd1, S_DROP = 3'd2, S_CLEAR = 3'd3, S_OVER = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [MEM_WIDTH-1:0] board   [MEM_HEIGHT];
  logic [MEM_WIDTH-1:0] board_n [MEM_HEIGHT];
  logic [15:0]          mask, mask_n;
  logic [XW-1:0]        px, px_n;
  logic [YW-1:0]        py, py_n, scan, scan_n;
  logic [GW-1:0]        grav, grav_n;
  logic [SCORE_WIDTH-1:0] lines, lines_n;
  logic                 accept, try_down;
  int                   lx, ly;

  // True when any set cell of m placed at (x, y) leaves the board or overlaps a locked cell.
  function automatic logic hits(input logic [15:0] m, input int x, input int y);
    logic h;
    int   cx, cy;
    h = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[4'(r * 4 + c)]) begin
          cx = x + c;
          cy = y + r;
          if (cx < 0 || cx >= MEM_WIDTH || cy < 0 || cy >= MEM_HEIGHT) h = 1'b1;
          else if (board[cy[YW-1:0]][cx[XW-1:0]]) h = 1'b1;
        end
      end
    end
    return h;
  endfunction

`ifdef TETRIS_ROTATE_EN
  // 90 degree clockwise turn inside the 4x4 box: new[r][c] = old[3-c][r].
  function automatic logic [15:0] rot_cw(input logic [15:0] m);
    logic [15:0] n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[4'(r * 4 + c)] = m[4'((3 - c) * 4 + r)];
    return n;
  endfunction
`endif

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Datapath registers; reset wins from any state, including mid-drop or mid-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_HEIGHT; i++) board[i] <= '0;
      mask  <= '0;
      px    <= '0;
      py    <= '0;
      scan  <= '0;
      grav  <= '0;
      lines <= '0;
    end else begin
      board <= board_n;
      mask  <= mask_n;
      px    <= px_n;
      py    <= py_n;
      scan  <= scan_n;
      grav  <= grav_n;
      lines <= lines_n;
    end
  end

  // Next-state and datapath update: moves, gravity, drop stepping, lock and line clear.
  always_comb begin
    state_n  = state;
    board_n  = board;
    mask_n   = mask;
    px_n     = px;
    py_n     = py;
    scan_n   = scan;
    grav_n   = grav;
    lines_n  = lines;
    try_down = 1'b0;
    lx       = 0;
    ly       = 0;
    case (state)
      S_IDLE: begin
        if (accept && bus.cmd_op == OP_SPAWN) begin
          mask_n  = bus.cmd_piece;
          px_n    = XW'(SPAWN_X);
          py_n    = '0;
          grav_n  = '0;
          state_n = hits(bus.cmd_piece, SPAWN_X, 0) ? S_OVER : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LEFT:  if (px != '0 && !hits(mask, int'(px) - 1, int'(py))) px_n = px - 1'b1;
            OP_RIGHT: if (int'(px) + 1 < MEM_WIDTH && !hits(mask, int'(px) + 1, int'(py)))
                        px_n = px + 1'b1;
            OP_DOWN:  try_down = 1'b1;
            OP_DROP:  state_n = S_DROP;
`ifdef TETRIS_ROTATE_EN
            OP_ROT:   if (!hits(rot_cw(mask), int'(px), int'(py))) mask_n = rot_cw(mask);
`endif
            default: ;
          endcase
        end
        // An accepted command on the fire cycle holds the counter so gravity fires next cycle.
        if (GRAVITY_PERIOD > 0) begin
          if (grav == GRAV_LAST) begin
            if (!accept) begin
              try_down = 1'b1;
              grav_n   = '0;
            end
          end else begin
            grav_n = grav + 1'b1;
          end
        end
      end
      S_DROP: try_down = 1'b1;
      S_CLEAR: begin
        if (&board[scan]) begin
          for (int i = 1; i < MEM_HEIGHT; i++)
            if (i <= int'(scan)) board_n[YW'(i)] = board[YW'(i - 1)];
          board_n[0] = '0;
          if (lines != '1) lines_n = lines + 1'b1;
        end else if (scan == '0) begin
          state_n = S_IDLE;
        end else begin
          scan_n = scan - 1'b1;
        end
      end
      default: ;
    endcase
    if (try_down) begin
      if (int'(py) + 1 < MEM_HEIGHT && !hits(mask, int'(px), int'(py) + 1)) begin
        py_n = py + 1'b1;
      end else begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            lx = int'(px) + c;
            ly = int'(py) + r;
            if (mask[4'(r * 4 + c)] && lx < MEM_WIDTH && ly < MEM_HEIGHT)
              board_n[ly[YW-1:0]][lx[XW-1:0]] = 1'b1;
          end
        end
        mask_n  = '0;
        state_n = S_CLEAR;
        scan_n  = YW'(MEM_HEIGHT - 1);
      end
    end
  end

  // FSM outputs.
  always_comb begin
    bus.cmd_ready = (state != S_DROP) && (state != S_CLEAR);
    bus.game_over = (state == S_OVER);
    bus.fsm_state = state;
  end

  // Row read port: locked row with the active piece cells overlaid.
  always_comb begin
    logic [MEM_WIDTH-1:0] row;
    int                   cx;
    row = '0;
    cx  = 0;
    if (int'(bus.row_sel) < MEM_HEIGHT) row = board[bus.row_sel];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cx = int'(px) + c;
        if (mask[4'(r * 4 + c)] && int'(py) + r == int'(bus.row_sel) && cx < MEM_WIDTH)
          row[cx[XW-1:0]] = 1'b1;
      end
    end
    bus.row_data = row;
  end

  assign bus.piece_x       = px;
  assign bus.piece_y       = py;
  assign bus.lines_cleared = lines;
endmodule

// File: tb/tb_tetris_core.sv
// Bench for tetris_core: directed scenarios plus random play on a board model,
// and a second instance with short gravity period for gravity timing.
`timescale 1ns/1ps
module tb_tetris_core;
  localparam int W   = 10;
  localparam int H   = 20;
  localparam int SW  = 16;
  localparam int SPX = 3;
  localparam int YW  = $clog2(H);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tetris_if #(.MEM_WIDTH(W), .MEM_HEIGHT(H), .SCORE_WIDTH(SW)) bus_a ();
  tetris_if #(.MEM_WIDTH(W), .MEM_HEIGHT(H), .SCORE_WIDTH(SW)) bus_g ();

  tetris_core #(.MEM_WIDTH(W), .MEM_HEIGHT(H), .GRAVITY_PERIOD(0), .SCORE_WIDTH(SW),
                .SPAWN_X(SPX)) dut (.clk(clk), .rst(rst), .bus(bus_a));
  tetris_core #(.MEM_WIDTH(W), .MEM_HEIGHT(H), .GRAVITY_PERIOD(4), .SCORE_WIDTH(SW),
                .SPAWN_X(SPX)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] mb [H];
  logic [W-1:0] exp_q [$];
  logic [15:0]  m_mask;
  int           m_x, m_y, m_lines, m_phase;  // phase: 0 idle, 1 active, 4 over

  logic [15:0] pieces [7] = '{16'h000F, 16'h0033, 16'h0027, 16'h0036, 16'h0063, 16'h0071, 16'h0074};

  function automatic bit m_fits(input logic [15:0] m, input int x, input int y);
    logic [W-1:0] rv;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[4'(r * 4 + c)]) begin
          if (x + c < 0 || x + c >= W || y + r < 0 || y + r >= H) return 1'b0;
          rv = mb[YW'(y + r)];
          if (rv[x + c]) return 1'b0;
        end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] m_row(input int row);
    logic [W-1:0] v;
    v = mb[YW'(row)];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_mask[4'(r * 4 + c)] && m_y + r == row && m_x + c < W)
          v = v | (W'(1) << (m_x + c));
    return v;
  endfunction

  function automatic logic [15:0] m_rot(input logic [15:0] m);
    logic [15:0] n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[4'(r * 4 + c)] = m[4'((3 - c) * 4 + r)];
    return n;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < H; r++) mb[r] = '0;
    m_mask = '0; m_x = 0; m_y = 0; m_lines = 0; m_phase = 0;
  endtask

  // Freeze the piece into the board, then drop every full row and refill from the top.
  task automatic m_lock(output int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_mask[4'(r * 4 + c)]) mb[YW'(m_y + r)] = mb[YW'(m_y + r)] | (W'(1) << (m_x + c));
    m_mask = '0;
    k = 0;
    exp_q.delete();
    for (int r = H - 1; r >= 0; r--)
      if (mb[r] == {W{1'b1}}) k++;
      else exp_q.push_back(mb[r]);
    for (int r = H - 1; r >= 0; r--)
      mb[r] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    m_lines = (m_lines + k > 65535) ? 65535 : m_lines + k;
    m_phase = 0;
  endtask

  // Apply one accepted command; busy = cycles the engine should hold cmd_ready low.
  task automatic m_apply(input int op, input logic [15:0] p, output int busy);
    int k, d;
    busy = 0;
    if (m_phase == 0) begin
      if (op == 5) begin
        m_mask = p; m_x = SPX; m_y = 0;
        m_phase = m_fits(p, SPX, 0) ? 1 : 4;
      end
    end else if (m_phase == 1) begin
      case (op)
        1: if (m_x > 0 && m_fits(m_mask, m_x - 1, m_y)) m_x--;
        2: if (m_fits(m_mask, m_x + 1, m_y)) m_x++;
        3: if (m_fits(m_mask, m_x, m_y + 1)) m_y++;
           else begin m_lock(k); busy = H + k; end
        4: begin
             d = 0;
             while (m_fits(m_mask, m_x, m_y + 1)) begin m_y++; d++; end
             m_lock(k);
             busy = d + 1 + H + k;
           end
`ifdef TETRIS_ROTATE_EN
        6: if (m_fits(m_rot(m_mask), m_x, m_y)) m_mask = m_rot(m_mask);
`endif
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    int r;
    check({tag, "/x"}, 32'(bus_a.piece_x), m_x);
    check({tag, "/y"}, 32'(bus_a.piece_y), m_y);
    check({tag, "/lines"}, 32'(bus_a.lines_cleared), m_lines);
    check({tag, "/over"}, 32'(bus_a.game_over), (m_phase == 4) ? 1 : 0);
    check({tag, "/state"}, 32'(bus_a.fsm_state), m_phase);
    r = $urandom_range(0, H - 1);
    bus_a.row_sel = YW'(r);
    #1;
    check({tag, "/row"}, 32'(bus_a.row_data), 32'(m_row(r)));
  endtask

  // Walks every row; the DUT is static here (no command, no gravity), so time may pass edges.
  task automatic check_board(input string tag);
    for (int r = 0; r < H; r++) begin
      bus_a.row_sel = YW'(r);
      #1;
      check($sformatf("%s/row%0d", tag, r), 32'(bus_a.row_data), 32'(m_row(r)));
    end
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic send_a(input int op, input logic [15:0] p, input string tag, output int seen);
    int n, busy;
    n = 0;
    while (!bus_a.cmd_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "/ready"}, 32'(bus_a.cmd_ready), 1);
    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_op    = 3'(op);
    bus_a.cmd_piece = p;
    @(posedge clk);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_op    = 3'd0;
    m_apply(op, p, busy);
    n = 0;
    while (!bus_a.cmd_ready && n < 4 * H + 40) begin n++; @(negedge clk); end
    check({tag, "/busy"}, n, busy);
    seen = n;
    check_regs(tag);
  endtask

  task automatic send_g(input int op, input logic [15:0] p);
    bus_g.cmd_valid = 1'b1;
    bus_g.cmd_op    = 3'(op);
    bus_g.cmd_piece = p;
    @(posedge clk);
    @(negedge clk);
    bus_g.cmd_valid = 1'b0;
    bus_g.cmd_op    = 3'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seen, pick, op;
    logic [15:0] p;
    rst = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 3'd0; bus_a.cmd_piece = '0; bus_a.row_sel = '0;
    bus_g.cmd_valid = 1'b0; bus_g.cmd_op = 3'd0; bus_g.cmd_piece = '0; bus_g.row_sel = '0;
    m_reset();
    do_reset();

    // Reset state
    check("reset/ready", 32'(bus_a.cmd_ready), 1);
    check_regs("reset");
    check_board("reset");

    // Spawn a horizontal I and slide it into the left wall
    send_a(5, 16'h000F, "spawn", seen);
    check("spawn/state", 32'(bus_a.fsm_state), 1);
    check("spawn/x", 32'(bus_a.piece_x), 3);
    bus_a.row_sel = '0; #1;
    check("spawn/row0", 32'(bus_a.row_data), 32'h078);
    for (int i = 0; i < 5; i++) begin
      send_a(1, '0, $sformatf("left%0d", i), seen);
      check($sformatf("left%0d/xc", i), 32'(bus_a.piece_x), (i < 3) ? 2 - i : 0);
    end
    send_a(4, '0, "drop1", seen);
    check("drop1/busyc", seen, 40);
    bus_a.row_sel = YW'(19); #1;
    check("drop1/row19", 32'(bus_a.row_data), 32'h00F);
    check_board("drop1");

    // Line clear
    send_a(5, 16'h000F, "lc_spawn1", seen);
    send_a(2, '0, "lc_right1", seen);
    send_a(4, '0, "lc_drop1", seen);
    send_a(5, 16'h0033, "lc_spawn2", seen);
    for (int i = 0; i < 6; i++) send_a(2, '0, $sformatf("lc_r%0d", i), seen);
    check("lc/xwall", 32'(bus_a.piece_x), 8);
    send_a(4, '0, "lc_drop2", seen);
    check("lc/busyc", seen, 40);
    check("lc/lines", 32'(bus_a.lines_cleared), 1);
    bus_a.row_sel = YW'(19); #1;
    check("lc/row19", 32'(bus_a.row_data), 32'h300);
    bus_a.row_sel = YW'(18); #1;
    check("lc/row18", 32'(bus_a.row_data), 32'h000);
    check_board("lc");

    // Game over on a stacked column
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_a(5, 16'h1111, $sformatf("go_spawn%0d", i), seen);
      send_a(4, '0, $sformatf("go_drop%0d", i), seen);
    end
    send_a(5, 16'h1111, "go_spawn5", seen);
    check("go/flag", 32'(bus_a.game_over), 1);
    send_a(1, '0, "go_left", seen);
    send_a(4, '0, "go_drop", seen);
    send_a(5, 16'h000F, "go_spawn", seen);
    check("go/flag2", 32'(bus_a.game_over), 1);
    check_board("go");

    // Reset in the middle of a hard drop
    do_reset();
    send_a(5, 16'h0033, "mid_spawn", seen);
    bus_a.cmd_valid = 1'b1; bus_a.cmd_op = 3'd4;
    @(posedge clk); @(negedge clk);
    bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 3'd0;
    repeat (3) @(negedge clk);
    check("mid/busy", 32'(bus_a.cmd_ready), 0);
    do_reset();
    check("mid/ready", 32'(bus_a.cmd_ready), 1);
    check_regs("mid");
    check_board("mid");

    // Rotation
    send_a(5, 16'h000F, "rot_spawn", seen);
    send_a(6, '0, "rot", seen);
    bus_a.row_sel = YW'(3); #1;
`ifdef TETRIS_ROTATE_EN
    check("rot/row3", 32'(bus_a.row_data), 32'h040);
`else
    check("rot/row3", 32'(bus_a.row_data), 32'h000);
    bus_a.row_sel = '0; #1;
    check("rot/row0", 32'(bus_a.row_data), 32'h078);
`endif
    @(negedge clk);

    // Random play
    do_reset();
    for (int s = 0; s < 250; s++) begin
      pick = $urandom_range(0, 99);
      if      (pick < 12) op = 1;
      else if (pick < 24) op = 2;
      else if (pick < 40) op = 3;
      else if (pick < 52) op = 4;
      else if (pick < 74) op = 5;
      else if (pick < 84) op = 6;
      else if (pick < 92) op = 0;
      else                op = 7;
      p = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535))
                                      : pieces[$urandom_range(0, 6)];
      send_a(op, p, $sformatf("rnd%0d", s), seen);
      if (seen > 0) check_board($sformatf("rnd%0d", s));
      if (m_phase == 4) begin
        check_board($sformatf("rnd%0d_over", s));
        do_reset();
      end
    end

    // Gravity timing on the period-4 instance
    do_reset();
    send_g(5, 16'h000F);
    check("grav/y0", 32'(bus_g.piece_y), 0);
    repeat (3) @(negedge clk);
    check("grav/y3cyc", 32'(bus_g.piece_y), 0);
    @(negedge clk);
    check("grav/y4cyc", 32'(bus_g.piece_y), 1);
    repeat (4) @(negedge clk);
    check("grav/y8cyc", 32'(bus_g.piece_y), 2);
    repeat (3) @(negedge clk);
    check("grav/y11cyc", 32'(bus_g.piece_y), 2);
    send_g(1, '0);
    check("grav/left_x", 32'(bus_g.piece_x), 2);
    check("grav/left_y", 32'(bus_g.piece_y), 2);
    @(negedge clk);
    check("grav/late_y", 32'(bus_g.piece_y), 3);
    check("grav/late_x", 32'(bus_g.piece_x), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
